// File: rtl/pll_lock_sequencer_pkg.sv
// Shared state encoding and constants for the PLL lock sequencer and its status logic.
package pll_lock_sequencer_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RUN       = 2'd2,
        LOST      = 2'd3
    } state_t;

    localparam logic [7:0] LOSS_MAX = 8'd255;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == LOSS_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-stage synchronizer for a single asynchronous level input.
module sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Qualifies PLL lock, releases the downstream synchronous reset, and tracks lock losses/timeouts.
module pll_lock_sequencer
    import pll_lock_sequencer_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter int unsigned RST_HOLD       = 16,
    parameter int unsigned CNT_W          = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       clear_flags,
    output logic       sys_rst,
    output logic       ready,
    output logic       lock_lost,
    output logic       timeout,
    output logic [7:0] loss_count
);

    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             locked_s;
    logic             timeout_set, loss_evt;
    logic             timeout_next, lock_lost_next;
    logic [7:0]       loss_count_next;

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        timeout_set = 1'b0;
        loss_evt    = 1'b0;
        case (state)
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_next = STABILIZE;
                    cnt_next   = '0;
                end else begin
                    if (cnt != '1) cnt_next = cnt + 1'b1;
                    if (cnt == TIMEOUT_LAST) timeout_set = 1'b1;
                end
            end
            STABILIZE: begin
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_next = LOST;
                    cnt_next   = '0;
                    loss_evt   = 1'b1;
                end
            end
            LOST: begin
                if (cnt == HOLD_LAST) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = WAIT_LOCK;
                cnt_next   = '0;
            end
        endcase
    end

    // A set/increment event in the same cycle as clear_flags wins over the clear.
    always_comb begin
        timeout_next    = timeout_set ? 1'b1 : (clear_flags ? 1'b0 : timeout);
        lock_lost_next  = loss_evt    ? 1'b1 : (clear_flags ? 1'b0 : lock_lost);
        loss_count_next = clear_flags ? 8'd0 : loss_count;
        if (loss_evt) loss_count_next = sat_inc(loss_count_next);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WAIT_LOCK;
            cnt        <= '0;
            sys_rst    <= 1'b1;
            ready      <= 1'b0;
            lock_lost  <= 1'b0;
            timeout    <= 1'b0;
            loss_count <= 8'd0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            sys_rst    <= (state_next != RUN);
            ready      <= (state_next == RUN);
            lock_lost  <= lock_lost_next;
            timeout    <= timeout_next;
            loss_count <= loss_count_next;
        end
    end

endmodule
